// File: rtl/dcache_controller.sv
// dcache_controller: direct-mapped, write-back, write-allocate L1 data cache.
// Hits are served combinationally with no stall. A miss stalls the pipeline,
// writes back a dirty victim if needed, then refills the line from memory.
// Ports:
//   clk_i, rst_i          clock, synchronous active-high reset
//   cpu_req_i/write_i     MEM-stage access valid / store select
//   cpu_addr_i/data_i     byte address (word aligned) / store data
//   cpu_data_o            load data, nonzero only on a read hit
//   cpu_stall_o           pipeline freeze request (combinational)
//   mem_enable_o/write_o  memory request active / write-back select (registered)
//   mem_addr_o/data_o     line address / write-back line (registered)
//   mem_data_i/ack_i      fetched line / one-cycle completion pulse
module dcache_controller #(
  parameter int unsigned NUM_LINES = 16,
  parameter int unsigned LINE_BITS = 256
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 cpu_req_i,
  input  logic                 cpu_write_i,
  input  logic [31:0]          cpu_addr_i,
  input  logic [31:0]          cpu_data_i,
  output logic [31:0]          cpu_data_o,
  output logic                 cpu_stall_o,
  output logic                 mem_enable_o,
  output logic                 mem_write_o,
  output logic [31:0]          mem_addr_o,
  output logic [LINE_BITS-1:0] mem_data_o,
  input  logic [LINE_BITS-1:0] mem_data_i,
  input  logic                 mem_ack_i
);

  localparam int unsigned IDX_W = $clog2(NUM_LINES);
  localparam int unsigned OFF_W = 3;
  localparam int unsigned TAG_W = 32 - 5 - IDX_W;
  localparam int unsigned SEL_W = $clog2(LINE_BITS);

  typedef enum logic [1:0] {IDLE, WRITEBACK, ALLOCATE} state_t;

  state_t state, state_next;

  logic [NUM_LINES-1:0] valid_q;
  logic [NUM_LINES-1:0] dirty_q;
  logic [TAG_W-1:0]     tag_q  [NUM_LINES];
  logic [LINE_BITS-1:0] line_q [NUM_LINES];

  logic [IDX_W-1:0] idx;
  logic [TAG_W-1:0] addr_tag;
  logic [OFF_W-1:0] off;
  logic [SEL_W-1:0] sel;
  logic             hit;
  logic             write_hit;
  logic             unused_addr_bits;

  // Address split: [1:0] byte, [4:2] word, then index, then tag.
  assign off              = cpu_addr_i[4:2];
  assign idx              = cpu_addr_i[5 +: IDX_W];
  assign addr_tag         = cpu_addr_i[31 -: TAG_W];
  assign sel              = SEL_W'({off, 5'd0});
  assign unused_addr_bits = ^cpu_addr_i[1:0];

  assign hit       = valid_q[idx] && (tag_q[idx] == addr_tag);
  assign write_hit = !rst_i && (state == IDLE) && cpu_req_i && cpu_write_i && hit;

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_next;
  end

  // Next state and combinational CPU-side outputs
  always_comb begin
    state_next  = state;
    cpu_stall_o = 1'b0;
    cpu_data_o  = 32'd0;
    unique case (state)
      IDLE: begin
        if (cpu_req_i && !hit) begin
          cpu_stall_o = 1'b1;
          state_next  = (valid_q[idx] && dirty_q[idx]) ? WRITEBACK : ALLOCATE;
        end else if (cpu_req_i && !cpu_write_i) begin
          cpu_data_o = line_q[idx][sel +: 32];
        end
      end
      WRITEBACK: begin
        cpu_stall_o = 1'b1;
        if (mem_ack_i) state_next = ALLOCATE;
      end
      ALLOCATE: begin
        cpu_stall_o = 1'b1;
        if (mem_ack_i) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    // Reset overrides everything, including an in-flight ack.
    if (rst_i) begin
      state_next  = IDLE;
      cpu_stall_o = 1'b0;
      cpu_data_o  = 32'd0;
    end
  end

  // Line storage: store-hit word update and refill on the allocate ack
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (write_hit) begin
      line_q[idx][sel +: 32] <= cpu_data_i;
      dirty_q[idx]           <= 1'b1;
    end else if ((state == ALLOCATE) && mem_ack_i) begin
      line_q[idx]  <= mem_data_i;
      tag_q[idx]   <= addr_tag;
      valid_q[idx] <= 1'b1;
      dirty_q[idx] <= 1'b0;
    end
  end

  // Memory-side outputs registered from the state being entered, so the
  // request is presented from the first cycle of WRITEBACK/ALLOCATE.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mem_enable_o <= 1'b0;
      mem_write_o  <= 1'b0;
      mem_addr_o   <= 32'd0;
      mem_data_o   <= '0;
    end else begin
      mem_enable_o <= (state_next != IDLE);
      mem_write_o  <= (state_next == WRITEBACK);
      if (state_next == WRITEBACK) begin
        mem_addr_o <= {tag_q[idx], idx, 5'd0};
        mem_data_o <= line_q[idx];
      end else if (state_next == ALLOCATE) begin
        mem_addr_o <= {addr_tag, idx, 5'd0};
        mem_data_o <= '0;
      end else begin
        mem_addr_o <= 32'd0;
        mem_data_o <= '0;
      end
    end
  end

endmodule

// File: tb/tb_dcache_controller.sv
// Testbench for dcache_controller: a flat word-addressed reference memory and
// a residency model predict load data, stall length and memory traffic; a
// CPU-side monitor and a memory responder check against queued expectations.
module tb_dcache_controller;

  logic         clk_i = 1'b0;
  logic         rst_i;
  logic         cpu_req_i;
  logic         cpu_write_i;
  logic [31:0]  cpu_addr_i;
  logic [31:0]  cpu_data_i;
  logic [31:0]  cpu_data_o;
  logic         cpu_stall_o;
  logic         mem_enable_o;
  logic         mem_write_o;
  logic [31:0]  mem_addr_o;
  logic [255:0] mem_data_o;
  logic [255:0] mem_data_i;
  logic         mem_ack_i;

  dcache_controller dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .cpu_req_i(cpu_req_i), .cpu_write_i(cpu_write_i),
    .cpu_addr_i(cpu_addr_i), .cpu_data_i(cpu_data_i),
    .cpu_data_o(cpu_data_o), .cpu_stall_o(cpu_stall_o),
    .mem_enable_o(mem_enable_o), .mem_write_o(mem_write_o),
    .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o),
    .mem_data_i(mem_data_i), .mem_ack_i(mem_ack_i)
  );

  always #5 clk_i = ~clk_i;

  typedef struct { logic is_read; logic [31:0] data; int stall; } cpu_exp_t;
  typedef struct { logic wr; logic [31:0] addr; logic [255:0] data; } mem_exp_t;

  cpu_exp_t cpu_q[$];
  mem_exp_t mem_q[$];

  int checks = 0;
  int errors = 0;
  int lat = 1;
  int spur_req = 0;
  logic mon_en = 1'b0;

  // Residency model plus flat reference memory (latest value of every word).
  logic        mvalid [16];
  logic        mdirty [16];
  logic [22:0] mtag   [16];
  logic [255:0] mem_store [int unsigned];
  logic [31:0]  ref_word  [int unsigned];

  function automatic logic [31:0] init_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  function automatic logic [255:0] mem_line(input logic [31:0] la);
    logic [255:0] l;
    if (mem_store.exists(la)) return mem_store[la];
    for (int k = 0; k < 8; k++) l[k*32 +: 32] = init_word(la + 32'(k*4));
    return l;
  endfunction

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    return ref_word.exists(a) ? ref_word[a] : init_word(a);
  endfunction

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic finish_run();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  endtask

  // Reset drops every line; dirty words revert to what memory holds.
  task automatic model_reset();
    logic [31:0]  la;
    logic [255:0] l;
    for (int i = 0; i < 16; i++) begin
      if (mvalid[i] && mdirty[i]) begin
        la = {mtag[i], 4'(i), 5'd0};
        l  = mem_line(la);
        for (int k = 0; k < 8; k++) ref_word[la + 32'(k*4)] = l[k*32 +: 32];
      end
      mvalid[i] = 1'b0;
      mdirty[i] = 1'b0;
    end
  endtask

  // Issue one CPU access, queue its expectations, hold it until it completes.
  task automatic access(input logic wr, input logic [31:0] a, input logic [31:0] d, input int l);
    logic [31:0]  aa;
    logic [3:0]   ix4;
    int           ix;
    logic [22:0]  tg;
    int           nreq;
    cpu_exp_t     ce;
    mem_exp_t     me;
    logic [255:0] vl;
    bit           done;
    aa   = {a[31:2], 2'b00};
    ix4  = aa[8:5];
    ix   = int'(ix4);
    tg   = aa[31:9];
    nreq = 0;
    if (!(mvalid[ix] && mtag[ix] == tg)) begin
      if (mvalid[ix] && mdirty[ix]) begin
        me.wr   = 1'b1;
        me.addr = {mtag[ix], ix4, 5'd0};
        for (int k = 0; k < 8; k++) vl[k*32 +: 32] = ref_rd(me.addr + 32'(k*4));
        me.data = vl;
        mem_q.push_back(me);
        nreq++;
      end
      me.wr   = 1'b0;
      me.addr = {tg, ix4, 5'd0};
      me.data = '0;
      mem_q.push_back(me);
      nreq++;
      mvalid[ix] = 1'b1;
      mtag[ix]   = tg;
      mdirty[ix] = 1'b0;
    end
    // Each memory request occupies l cycles; stall also covers the miss cycle.
    ce.is_read = !wr;
    ce.data    = wr ? 32'd0 : ref_rd(aa);
    ce.stall   = (nreq == 0) ? 0 : nreq * l + 1;
    cpu_q.push_back(ce);
    if (wr) begin
      ref_word[aa] = d;
      mdirty[ix]   = 1'b1;
    end
    lat         = l;
    cpu_req_i   = 1'b1;
    cpu_write_i = wr;
    cpu_addr_i  = a;
    cpu_data_i  = d;
    done = 1'b0;
    for (int c = 0; c < 2000 && !done; c++) begin
      @(negedge clk_i);
      if (!cpu_stall_o) done = 1'b1;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL access_timeout addr=%0h stall=%0b required=stall released", a, cpu_stall_o);
      finish_run();
    end
    @(posedge clk_i);
    #1;
    cpu_req_i = 1'b0;
  endtask

  // CPU-side monitor: counts stall cycles and checks each completing access.
  initial begin
    int       scnt;
    cpu_exp_t ce;
    scnt = 0;
    forever begin
      @(negedge clk_i);
      if (!mon_en || !cpu_req_i || rst_i) scnt = 0;
      else if (cpu_stall_o) scnt++;
      else begin
        if (cpu_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL cpu_unexpected_completion addr=%0h required=no completion", cpu_addr_i);
        end else begin
          ce = cpu_q.pop_front();
          check("stall_cycles", 256'(scnt), 256'(ce.stall));
          check(ce.is_read ? "load_data" : "store_cycle_data_o", 256'(cpu_data_o), 256'(ce.data));
        end
        scnt = 0;
      end
    end
  end

  // Memory responder: checks each request, acks after lat cycles.
  initial begin
    int          spur_done;
    mem_exp_t    me;
    logic        wr_now;
    logic [31:0] addr_now;
    bit          aborted;
    spur_done  = 0;
    mem_ack_i  = 1'b0;
    mem_data_i = '0;
    forever begin
      @(negedge clk_i);
      if (spur_req != spur_done) begin
        spur_done++;
        mem_data_i = {8{32'hBAD0_BAD0}};
        mem_ack_i  = 1'b1;
        @(posedge clk_i);
        #1 mem_ack_i = 1'b0;
      end else if (mem_enable_o && !rst_i) begin
        wr_now   = mem_write_o;
        addr_now = mem_addr_o;
        if (mem_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL mem_unexpected_request addr=%0h write=%0b required=no request", mem_addr_o, mem_write_o);
        end else begin
          me = mem_q.pop_front();
          check("mem_write_o", 256'(mem_write_o), 256'(me.wr));
          check("mem_addr_o", 256'(mem_addr_o), 256'(me.addr));
          check(me.wr ? "mem_data_o_writeback" : "mem_data_o_fetch", mem_data_o, me.data);
        end
        if (wr_now) mem_store[addr_now] = mem_data_o;
        aborted = 1'b0;
        for (int k = 1; k < lat && !aborted; k++) begin
          @(negedge clk_i);
          if (rst_i) aborted = 1'b1;
        end
        if (aborted) begin
          // Late ack for an abandoned request, with junk data.
          while (rst_i) @(negedge clk_i);
          mem_data_i = {8{32'hDEAD_DEAD}};
        end else if (!wr_now) begin
          mem_data_i = mem_line(addr_now);
        end
        mem_ack_i = 1'b1;
        @(posedge clk_i);
        #1 mem_ack_i = 1'b0;
      end
    end
  end

  initial begin
    logic [31:0] a;
    rst_i = 1'b1;
    cpu_req_i = 1'b1;
    cpu_write_i = 1'b0;
    cpu_addr_i = 32'h40;
    cpu_data_i = 32'd0;
    for (int i = 0; i < 16; i++) begin
      mvalid[i] = 1'b0;
      mdirty[i] = 1'b0;
      mtag[i]   = '0;
    end

    // Reset with a request present: outputs forced low and zeroed.
    @(posedge clk_i);
    @(negedge clk_i);
    check("rst_cpu_stall_o", 256'(cpu_stall_o), 256'(0));
    check("rst_cpu_data_o", 256'(cpu_data_o), 256'(0));
    check("rst_mem_enable_o", 256'(mem_enable_o), 256'(0));
    check("rst_mem_write_o", 256'(mem_write_o), 256'(0));
    check("rst_mem_addr_o", 256'(mem_addr_o), 256'(0));
    check("rst_mem_data_o", mem_data_o, 256'(0));
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    cpu_req_i = 1'b0;
    mon_en = 1'b1;

    // Directed sequence: cold load, store hit, dirty eviction, write miss.
    access(1'b0, 32'h0000_0004, 32'd0, 10);
    access(1'b1, 32'h0000_0008, 32'hDEAD_BEEF, 1);
    access(1'b0, 32'h0000_0008, 32'd0, 1);
    access(1'b0, 32'h0000_0208, 32'd0, 3);
    access(1'b1, 32'h0000_0024, 32'h1234_5678, 2);
    access(1'b0, 32'h0000_0220, 32'd0, 2);

    // Spurious ack while idle changes nothing; resident line still hits.
    spur_req++;
    repeat (3) @(posedge clk_i);
    #1;
    @(negedge clk_i);
    check("spur_mem_enable_o", 256'(mem_enable_o), 256'(0));
    @(posedge clk_i);
    #1;
    access(1'b0, 32'h0000_0208, 32'd0, 1);

    // Reset during ALLOCATE abandons the refill and invalidates everything.
    mon_en = 1'b0;
    mem_q.push_back('{wr: 1'b0, addr: 32'h0000_0300, data: '0});
    lat = 1000;
    cpu_req_i = 1'b1;
    cpu_write_i = 1'b0;
    cpu_addr_i = 32'h0000_0300;
    repeat (3) @(negedge clk_i);
    check("alloc_cpu_stall_o", 256'(cpu_stall_o), 256'(1));
    check("alloc_mem_enable_o", 256'(mem_enable_o), 256'(1));
    @(posedge clk_i);
    #1;
    rst_i = 1'b1;
    cpu_req_i = 1'b0;
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    @(negedge clk_i);
    check("abort_mem_enable_o", 256'(mem_enable_o), 256'(0));
    repeat (3) @(negedge clk_i);
    check("late_ack_mem_enable_o", 256'(mem_enable_o), 256'(0));
    model_reset();
    @(posedge clk_i);
    #1;
    lat = 1;
    mon_en = 1'b1;
    access(1'b0, 32'h0000_0208, 32'd0, 2);

    // Sweep all indices with latency 1: first pass misses, second pass hits.
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < 16; i++)
        access(1'b0, 32'(i) << 5, 32'd0, 1);

    // Randomized traffic over four tags to force conflicts and evictions.
    for (int n = 0; n < 400; n++) begin
      a = (32'($urandom_range(0, 3)) << 9) | (32'($urandom_range(0, 15)) << 5)
        | (32'($urandom_range(0, 7)) << 2) | 32'($urandom_range(0, 3));
      if ($urandom_range(0, 9) < 2) begin
        repeat ($urandom_range(1, 2)) @(posedge clk_i);
        #1;
      end
      access(1'($urandom_range(0, 1)), a, $urandom, $urandom_range(1, 4));
    end

    repeat (5) @(negedge clk_i);
    check("cpu_expectations_left", 256'(cpu_q.size()), 256'(0));
    check("mem_expectations_left", 256'(mem_q.size()), 256'(0));
    finish_run();
  end

endmodule
